hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl_sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU package for pipeline hazard control: register-address width,
// controller states and the load-use detection helper.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WAIT_W     = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // x0 is hardwired zero, so a load targeting it never creates a hazard
    function automatic logic load_use(input logic      memread,
                                      input reg_addr_t rd,
                                      input reg_addr_t rs1,
                                      input reg_addr_t rs2);
        return memread && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: decode/execute
// register fields and memory handshake in, stall/flush controls out.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    reg_addr_t        rs1_i;
    reg_addr_t        rs2_i;
    logic             id_ex_memread_i;
    reg_addr_t        id_ex_rd_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             id_ex_bubble_o;
    logic             if_id_flush_o;
    logic             pipe_hold_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  rs1_i, rs2_i, id_ex_memread_i, id_ex_rd_i, branch_taken_i,
               dmem_req_i, dmem_ready_i,
        output pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o,
               pipe_hold_o, err_o, stall_cnt_o
    );

    modport master (
        output rs1_i, rs2_i, id_ex_memread_i, id_ex_rd_i, branch_taken_i,
               dmem_req_i, dmem_ready_i,
        input  pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o,
               pipe_hold_o, err_o, stall_cnt_o
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall with timeout, load-use bubble
// and taken-branch flush, plus a saturating count of stalled cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    hazard_ctrl_if.slave  hz
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              w_mem_stall;
    logic              w_lu;
    logic              w_pc_write;
    logic              w_if_id_write;
    logic              w_id_ex_bubble;
    logic              w_if_id_flush;
    logic              w_pipe_hold;
    logic [CNT_W-1:0]  w_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_stall    = 1'b0;
        w_lu           = load_use(hz.id_ex_memread_i, hz.id_ex_rd_i, hz.rs1_i, hz.rs2_i);

        case (r_state)
            RUN: begin
                if (hz.dmem_req_i && !hz.dmem_ready_i) begin
                    w_mem_stall    = 1'b1;
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = '0;
                end
            end
            MEM_WAIT: begin
                // ready on the final allowed cycle still completes normally
                if (hz.dmem_ready_i) begin
                    w_state_nxt = RUN;
                end else begin
                    w_mem_stall    = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt = ERR;
                    end
                end
            end
            ERR: begin
                w_mem_stall = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase

        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_if_id_flush  = 1'b0;
        w_pipe_hold    = 1'b0;

        if (w_mem_stall) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_pipe_hold   = 1'b1;
        end else if (w_lu) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
        end else if (hz.branch_taken_i) begin
            w_if_id_flush = 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc     (w_mem_stall || w_lu),
        .clear   (1'b0),
        .o_count (w_stall_cnt)
    );

    assign hz.pc_write_o     = w_pc_write;
    assign hz.if_id_write_o  = w_if_id_write;
    assign hz.id_ex_bubble_o = w_id_ex_bubble;
    assign hz.if_id_flush_o  = w_if_id_flush;
    assign hz.pipe_hold_o    = w_pipe_hold;
    assign hz.err_o          = (r_state == ERR);
    assign hz.stall_cnt_o    = w_stall_cnt;

endmodule
